// File: rtl/rob_commit_if.sv
// Commit-stage bundle between the reorder buffer head and the retire logic.
// master = rob_commit (retire side), slave = RoB / register file / store buffer side.
interface rob_commit_if #(parameter int BITS = 4);
  logic            head_occupied;
  logic            head_ready;
  logic [1:0]      head_type;
  logic [31:0]     head_value;
  logic [31:0]     head_dest;
  logic            head_taken;
  logic            st_ack;
  logic [BITS-1:0] rob_head;
  logic            rf_we;
  logic [4:0]      rf_rd;
  logic [31:0]     rf_value;
  logic [BITS-1:0] rf_robid;
  logic            st_commit;
  logic            flush;
  logic [31:0]     flush_pc;
  logic            jalr_release;
  logic [31:0]     commit_cnt;
  logic [1:0]      dbg_state;

  // Handshake: an entry retires only when head_occupied && head_ready are high at a
  // clock edge in RUN; a store holds the head until st_ack arrives in a later cycle
  // than its st_commit pulse.
  modport master (
    input  head_occupied, head_ready, head_type, head_value, head_dest, head_taken, st_ack,
    output rob_head, rf_we, rf_rd, rf_value, rf_robid, st_commit, flush, flush_pc,
           jalr_release, commit_cnt, dbg_state
  );
  modport slave (
    output head_occupied, head_ready, head_type, head_value, head_dest, head_taken, st_ack,
    input  rob_head, rf_we, rf_rd, rf_value, rf_robid, st_commit, flush, flush_pc,
           jalr_release, commit_cnt, dbg_state
  );
endinterface

// File: rtl/rob_commit.sv
// In-order retire stage of the reorder buffer: one entry per cycle, store wait, flush.
// Optional retired-instruction counter enabled by defining ROB_COMMIT_CNT_EN.
module rob_commit #(
    parameter int BITS = 4,
    parameter int SIZE = 16
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         rdy_in,
    rob_commit_if.master bus
);
    typedef enum logic [1:0] {RUN = 2'd0, ST_WAIT = 2'd1, FLUSH = 2'd2} state_t;

    localparam logic [BITS-1:0] LAST = BITS'(SIZE - 1);

    state_t          state_q, state_d;
    logic [BITS-1:0] head_q, head_d;
    logic            rf_we_q, rf_we_d;
    logic [4:0]      rf_rd_q, rf_rd_d;
    logic [31:0]     rf_value_q, rf_value_d;
    logic [BITS-1:0] rf_robid_q, rf_robid_d;
    logic            st_commit_q, st_commit_d;
    logic            flush_q, flush_d;
    logic [31:0]     flush_pc_q, flush_pc_d;
    logic            jalr_q, jalr_d;
    logic            fire;
    logic            mispredict;
    logic            ack_ok;
    logic            retire;

    assign fire       = rdy_in && bus.head_occupied && bus.head_ready;
    assign mispredict = bus.head_taken != bus.head_value[0];
    // The ack sampled while st_commit is still high belongs to nothing we issued.
    assign ack_ok     = rdy_in && bus.st_ack && !st_commit_q;

    always_ff @(posedge clk_in) begin
        if (!rst_in) state_q <= RUN;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (rdy_in) begin
            case (state_q)
                RUN: begin
                    if (fire && bus.head_type == 2'd1 && mispredict) state_d = FLUSH;
                    else if (fire && bus.head_type == 2'd2)          state_d = ST_WAIT;
                end
                ST_WAIT: if (ack_ok) state_d = RUN;
                FLUSH:   state_d = RUN;
                default: state_d = RUN;
            endcase
        end
    end

    always_comb begin
        head_d      = head_q;
        rf_we_d     = 1'b0;
        rf_rd_d     = rf_rd_q;
        rf_value_d  = rf_value_q;
        rf_robid_d  = rf_robid_q;
        st_commit_d = 1'b0;
        flush_d     = 1'b0;
        flush_pc_d  = flush_pc_q;
        jalr_d      = 1'b0;
        retire      = 1'b0;
        if (rdy_in) begin
            case (state_q)
                RUN: begin
                    if (fire) begin
                        case (bus.head_type)
                            2'd0, 2'd3: begin
                                rf_we_d    = bus.head_dest[4:0] != 5'd0;
                                rf_rd_d    = bus.head_dest[4:0];
                                rf_value_d = bus.head_value;
                                rf_robid_d = head_q;
                                jalr_d     = bus.head_type == 2'd3;
                                retire     = 1'b1;
                            end
                            2'd1: begin
                                if (mispredict) begin
                                    flush_d    = 1'b1;
                                    flush_pc_d = bus.head_dest;
                                end else begin
                                    retire = 1'b1;
                                end
                            end
                            default: st_commit_d = 1'b1;
                        endcase
                    end
                end
                ST_WAIT: retire = ack_ok;
                // The RoB clears its tail on flush, so the head restarts at entry 0.
                FLUSH:   head_d = '0;
                default: ;
            endcase
        end
        if (retire) head_d = (head_q == LAST) ? '0 : head_q + 1'b1;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            head_q      <= '0;
            rf_we_q     <= 1'b0;
            rf_rd_q     <= '0;
            rf_value_q  <= '0;
            rf_robid_q  <= '0;
            st_commit_q <= 1'b0;
            flush_q     <= 1'b0;
            flush_pc_q  <= '0;
            jalr_q      <= 1'b0;
        end else begin
            head_q      <= head_d;
            rf_we_q     <= rf_we_d;
            rf_rd_q     <= rf_rd_d;
            rf_value_q  <= rf_value_d;
            rf_robid_q  <= rf_robid_d;
            st_commit_q <= st_commit_d;
            flush_q     <= flush_d;
            flush_pc_q  <= flush_pc_d;
            jalr_q      <= jalr_d;
        end
    end

`ifdef ROB_COMMIT_CNT_EN
    logic [31:0] cnt_q, cnt_d;

    // A mispredicted branch retires too, even though the head jumps to 0 afterwards.
    always_comb cnt_d = (retire || flush_d) ? cnt_q + 32'd1 : cnt_q;

    always_ff @(posedge clk_in) begin
        if (!rst_in) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign bus.commit_cnt = cnt_q;
`else
    assign bus.commit_cnt = 32'd0;
`endif

    assign bus.rob_head     = head_q;
    assign bus.rf_we        = rf_we_q;
    assign bus.rf_rd        = rf_rd_q;
    assign bus.rf_value     = rf_value_q;
    assign bus.rf_robid     = rf_robid_q;
    assign bus.st_commit    = st_commit_q;
    assign bus.flush        = flush_q;
    assign bus.flush_pc     = flush_pc_q;
    assign bus.jalr_release = jalr_q;
    assign bus.dbg_state    = state_q;
endmodule

// File: doc/rob_commit.md
ROB_COMMIT -- requirements
Module: rob_commit

Interface
REQ-001 SHALL have parameter BITS, default 4, giving the RoB index width.
REQ-002 SHALL have parameter SIZE, default 16, giving the RoB entry count (2**BITS).
REQ-003 SHALL have ports clk_in  input  1  system clock; the only clock.
REQ-004 SHALL have ports rst_in  input  1  reset, synchronous and active-low.
REQ-005 SHALL have ports rdy_in  input  1  ready; all state holds while low.
REQ-006 SHALL have ports head_occupied  input  1  RoB[head] holds an issued entry.
REQ-007 SHALL have ports head_ready  input  1  RoB[head] result is written back.
REQ-008 SHALL have ports head_type  input  2  entry kind: 0 reg-write, 1 branch, 2 store, 3 jalr.
REQ-009 SHALL have ports head_value  input  32  result; for a branch, bit0 is the predicted-taken flag.
REQ-010 SHALL have ports head_dest  input  32  rd in [4:0]; for a branch, the PC to use if the prediction fails.
REQ-011 SHALL have ports head_taken  input  1  resolved branch outcome.
REQ-012 SHALL have ports st_ack  input  1  load/store buffer has performed the committed store.
REQ-013 SHALL have ports rob_head  output  BITS  current head index.
REQ-014 SHALL have ports rf_we/rf_rd/rf_value/rf_robid  output  1/5/32/BITS  register-file commit.
REQ-015 SHALL have ports st_commit  output  1  store at head may perform.
REQ-016 SHALL have ports flush/flush_pc  output  1/32  misprediction recovery.
REQ-017 SHALL have ports jalr_release  output  1  clears the issue-side jalr stall.
REQ-018 SHALL have ports commit_cnt  output  32  retired-instruction count.

Function
REQ-019 SHALL implement an FSM with states RUN, ST_WAIT and FLUSH, and retire at most one entry per cycle.
REQ-020 In RUN, with head_occupied && head_ready: type 0 SHALL assert rf_we for one cycle with rf_rd = head_dest[4:0], rf_value = head_value and rf_robid = head, then advance head.
REQ-021 A type 0 entry with rd = 0 SHALL retire with rf_we low.
REQ-022 A type 3 (jalr) entry SHALL retire like type 0 and also pulse jalr_release in the same cycle.
REQ-023 Type 1 (branch): if head_taken == head_value[0], the entry SHALL retire with no other output; otherwise flush SHALL pulse for one cycle with flush_pc = head_dest, and the state SHALL go to FLUSH.
REQ-024 Type 2 (store): st_commit SHALL pulse for one cycle and the state SHALL go to ST_WAIT; head SHALL NOT advance yet.
REQ-025 In ST_WAIT, st_ack SHALL advance head and return the state to RUN; st_ack in the same cycle as st_commit SHALL be ignored.
REQ-026 In FLUSH, head SHALL be 0 on the next cycle (matching the RoB tail clear), and the state SHALL return to RUN one cycle later.
REQ-027 The head index SHALL wrap from SIZE-1 to 0.
REQ-028 If head_occupied is low or head_ready is low, the block SHALL hold, with all pulse outputs low.
REQ-029 All pulse outputs SHALL be registered, one cycle wide, and never asserted together except rf_we with jalr_release.
REQ-030 While rdy_in is low, the block SHALL keep all state, drive pulse outputs low, and perform no transitions.

Reset
REQ-031 With rst_in low at a clock edge, the block SHALL set state = RUN, rob_head = 0, commit_cnt = 0, rf_rd/rf_value/rf_robid/flush_pc = 0, and all pulses = 0.
REQ-032 Reset SHALL override rdy_in.
REQ-033 Reset during ST_WAIT or FLUSH SHALL abandon the pending operation with no further pulses.

Configuration
REQ-034 With macro ROB_COMMIT_CNT_EN defined, commit_cnt SHALL increment by 1 on every head advance (stores on ack, mispredicted branches included), wrapping at 2**32.
REQ-035 Without ROB_COMMIT_CNT_EN, commit_cnt SHALL be constant 0 and no counter register SHALL exist.

Verification
REQ-036 Reg-write: head=0, type 0, dest=5, value=0x1234, ready -> next cycle rf_we=1, rf_rd=5, rf_value=0x1234, rf_robid=0, then rob_head=1.
REQ-037 Correct branch: value=0x1001, taken=1 -> no flush, rob_head advances by 1.
REQ-038 Mispredict: value=0x1000, taken=1, dest=0x2000 -> flush=1 with flush_pc=0x2000 for one cycle, then rob_head=0 and state RUN.
REQ-039 Store: st_commit pulses once; hold st_ack low for 3 cycles -> rob_head unchanged; st_ack=1 -> rob_head+1.
REQ-040 Wrap and jalr: head=15, type 3 -> rf_we=1 and jalr_release=1 in the same cycle, then rob_head=0; with ROB_COMMIT_CNT_EN, commit_cnt=1.
REQ-041 rdy_in low for 2 cycles with a ready head -> no pulses; rst_in low mid-ST_WAIT -> all outputs 0.
